// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the forwarding/hazard unit.
//   - Bypass select encodings driven onto the EX operand muxes.
//   - Load-use FSM state type.
//   - rd_hit(): "this stage writes rd, rd is not x0, and rd equals rs".
//     Its arguments are RD_W bits wide, so callers zero-extend their
//     AW-bit addresses. This keeps one helper usable for any AW <= RD_W.
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_WB2   = 2'b11;

  localparam int RD_W = 32;

  typedef enum logic {IDLE, LU_HOLD} lu_state_e;

  function automatic logic rd_hit(input logic [RD_W-1:0] rd,
                                  input logic            wb,
                                  input logic [RD_W-1:0] rs);
    return wb && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel_one.sv
// fwd_sel_one: bypass select for a single EX source operand.
// Ports:
//   rs_i                 source register of this operand
//   mem_rd_i / mem_wb_i  EX/MEM destination and regwrite
//   wb_rd_i  / wb_wb_i   MEM/WB destination and regwrite
//   wb2_rd_i / wb2_wb_i  post-WB destination and regwrite
//   sel_o                00 regfile, 10 EX/MEM, 01 MEM/WB, 11 post-WB
// Build option: WB_BYPASS_EN enables the post-WB (11) select. Without it,
// the wb2 inputs are ignored.
module fwd_sel_one
  import fwd_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic          mem_wb_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic          wb_wb_i,
  input  logic [AW-1:0] wb2_rd_i,
  input  logic          wb2_wb_i,
  output logic [1:0]    sel_o
);

  // The checks run from oldest stage to youngest.
  // A later match overrides an earlier one, so the youngest producer
  // (EX/MEM) always wins.
  always_comb begin
    sel_o = FWD_RF;
`ifdef WB_BYPASS_EN
    if (rd_hit(RD_W'(wb2_rd_i), wb2_wb_i, RD_W'(rs_i))) sel_o = FWD_WB2;
`endif
    if (rd_hit(RD_W'(wb_rd_i), wb_wb_i, RD_W'(rs_i)))   sel_o = FWD_MEMWB;
    if (rd_hit(RD_W'(mem_rd_i), mem_wb_i, RD_W'(rs_i))) sel_o = FWD_EXMEM;
  end

`ifndef WB_BYPASS_EN
  logic unused_wb2;
  assign unused_wb2 = ^{wb2_rd_i, wb2_wb_i};
`endif

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding, load-use stall and multicycle
// scoreboard for the RV32 pipeline.
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   id_rs_i               ID source regs, operand i at [i*AW +: AW]
//   ex_rs_i               EX source regs, same packing
//   ex_rd_i/ex_wb_i/ex_load_i  EX destination, regwrite, is-load
//   mem_rd_i/mem_wb_i     EX/MEM destination and regwrite
//   wb_rd_i/wb_wb_i       MEM/WB destination and regwrite
//   wb2_rd_i/wb2_wb_i     post-WB destination and regwrite
//   mc_start_i/mc_rd_i    multicycle op issue and its destination
//   fwd_sel_o             2-bit bypass select per operand
//   stall_o/bubble_o      hold PC + IF/ID, zero ID/EX control
//   mc_busy_o             multicycle op in flight
//   mc_overrun_o          sticky: an issue arrived while busy
// Build option: WB_BYPASS_EN enables the post-WB bypass select (11).
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NRS      = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NRS*AW-1:0] id_rs_i,
  input  logic [NRS*AW-1:0] ex_rs_i,
  input  logic [AW-1:0]     ex_rd_i,
  input  logic              ex_wb_i,
  input  logic              ex_load_i,
  input  logic [AW-1:0]     mem_rd_i,
  input  logic              mem_wb_i,
  input  logic [AW-1:0]     wb_rd_i,
  input  logic              wb_wb_i,
  input  logic [AW-1:0]     wb2_rd_i,
  input  logic              wb2_wb_i,
  input  logic              mc_start_i,
  input  logic [AW-1:0]     mc_rd_i,
  output logic [NRS*2-1:0]  fwd_sel_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              mc_busy_o,
  output logic              mc_overrun_o
);

  localparam int LU_CW = (LOAD_LAT > 2) ? $clog2(LOAD_LAT) : 1;
  localparam int MC_CW = $clog2(MC_LAT);
  localparam logic [LU_CW-1:0] LU_INIT = LU_CW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [MC_CW-1:0] MC_INIT = MC_CW'(MC_LAT - 1);

  lu_state_e        state_q;
  logic [LU_CW-1:0] lu_cnt_q;
  logic             mc_busy_q, mc_busy_d;
  logic [MC_CW-1:0] mc_cnt_q, mc_cnt_d;
  logic [AW-1:0]    mc_rd_q, mc_rd_d;
  logic             mc_overrun_q, mc_overrun_d;
  logic             lu_hit, mc_hit, lu_stall;

  for (genvar g = 0; g < NRS; g++) begin : g_fwd
    fwd_sel_one #(.AW(AW)) u_sel (
      .rs_i     (ex_rs_i[g*AW +: AW]),
      .mem_rd_i (mem_rd_i),
      .mem_wb_i (mem_wb_i),
      .wb_rd_i  (wb_rd_i),
      .wb_wb_i  (wb_wb_i),
      .wb2_rd_i (wb2_rd_i),
      .wb2_wb_i (wb2_wb_i),
      .sel_o    (fwd_sel_o[g*2 +: 2])
    );
  end

  // Stall causes. A load in EX stalls when it feeds any ID operand.
  // A busy multicycle op stalls when its pending rd is read in ID.
  always_comb begin
    lu_hit = 1'b0;
    mc_hit = 1'b0;
    for (int i = 0; i < NRS; i++) begin
      if (rd_hit(RD_W'(ex_rd_i), ex_load_i & ex_wb_i, RD_W'(id_rs_i[i*AW +: AW])))
        lu_hit = 1'b1;
      if (rd_hit(RD_W'(mc_rd_q), mc_busy_q, RD_W'(id_rs_i[i*AW +: AW])))
        mc_hit = 1'b1;
    end
  end

  // The first stall cycle comes straight from lu_hit, with no register
  // delay. LU_HOLD supplies the remaining LOAD_LAT-1 cycles.
  assign lu_stall     = (state_q == LU_HOLD) | lu_hit;
  assign stall_o      = ~rst_i & (lu_stall | mc_hit);
  assign bubble_o     = stall_o;
  assign mc_busy_o    = mc_busy_q;
  assign mc_overrun_o = mc_overrun_q;

  // Load-use FSM. With LOAD_LAT == 1 the single combinational stall
  // cycle is enough, so it never leaves IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      lu_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lu_hit && (LOAD_LAT > 1)) begin
            state_q  <= LU_HOLD;
            lu_cnt_q <= LU_INIT;
          end
        end
        LU_HOLD: begin
          if (lu_cnt_q == '0) state_q  <= IDLE;
          else                lu_cnt_q <= lu_cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Multicycle scoreboard. Busy is held while the count runs from
  // MC_LAT-1 down to 0, then drops on the following edge, giving MC_LAT
  // busy cycles. An issue that arrives while busy is dropped and flagged.
  always_comb begin
    mc_busy_d    = mc_busy_q;
    mc_cnt_d     = mc_cnt_q;
    mc_rd_d      = mc_rd_q;
    mc_overrun_d = mc_overrun_q;
    if (mc_busy_q) begin
      if (mc_cnt_q == '0) mc_busy_d = 1'b0;
      else                mc_cnt_d  = mc_cnt_q - 1'b1;
      if (mc_start_i)     mc_overrun_d = 1'b1;
    end else if (mc_start_i) begin
      mc_busy_d = 1'b1;
      mc_cnt_d  = MC_INIT;
      mc_rd_d   = mc_rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mc_busy_q    <= 1'b0;
      mc_cnt_q     <= '0;
      mc_rd_q      <= '0;
      mc_overrun_q <= 1'b0;
    end else begin
      mc_busy_q    <= mc_busy_d;
      mc_cnt_q     <= mc_cnt_d;
      mc_rd_q      <= mc_rd_d;
      mc_overrun_q <= mc_overrun_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench for fwd_hazard_unit.
// It uses LOAD_LAT=3 and MC_LAT=4.
// Inputs are driven on the falling edge. Each cycle's expected outputs
// are queued at that point, then popped and compared 2 ns later,
// well before the next rising edge.
module tb_fwd_hazard_unit;

  localparam int NRS      = 2;
  localparam int AW       = 5;
  localparam int LOAD_LAT = 3;
  localparam int MC_LAT   = 4;

`ifdef WB_BYPASS_EN
  localparam logic [1:0] WB2EXP = 2'b11;
`else
  localparam logic [1:0] WB2EXP = 2'b00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NRS*AW-1:0] idRs, exRs;
  logic [AW-1:0]     exRd, memRd, wbRd, wb2Rd, mcRd;
  logic              exWb, exLoad, memWb, wbWb, wb2Wb, mcStart;
  logic [NRS*2-1:0]  fwdSel;
  logic              stall, bubble, mcBusy, mcOverrun;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [3:0] fwd;
    logic       stall;
    logic       busy;
    logic       ovr;
  } expT;

  expT sbQ[$];

  fwd_hazard_unit #(
    .NRS(NRS), .AW(AW), .LOAD_LAT(LOAD_LAT), .MC_LAT(MC_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_rs_i      (idRs),
    .ex_rs_i      (exRs),
    .ex_rd_i      (exRd),
    .ex_wb_i      (exWb),
    .ex_load_i    (exLoad),
    .mem_rd_i     (memRd),
    .mem_wb_i     (memWb),
    .wb_rd_i      (wbRd),
    .wb_wb_i      (wbWb),
    .wb2_rd_i     (wb2Rd),
    .wb2_wb_i     (wb2Wb),
    .mc_start_i   (mcStart),
    .mc_rd_i      (mcRd),
    .fwd_sel_o    (fwdSel),
    .stall_o      (stall),
    .bubble_o     (bubble),
    .mc_busy_o    (mcBusy),
    .mc_overrun_o (mcOverrun)
  );

  // Single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs
  task automatic sampleOutputs();
    expT e;
    if (sbQ.size() == 0) begin
      checkOutput("sbEmpty", 32'd1, 32'd0);
      return;
    end
    e = sbQ.pop_front();
    checkOutput({e.tag, ".fwd"},    32'(fwdSel),    32'(e.fwd));
    checkOutput({e.tag, ".stall"},  32'(stall),     32'(e.stall));
    checkOutput({e.tag, ".bubble"}, 32'(bubble),    32'(e.stall));
    checkOutput({e.tag, ".busy"},   32'(mcBusy),    32'(e.busy));
    checkOutput({e.tag, ".ovr"},    32'(mcOverrun), 32'(e.ovr));
  endtask

  // The caller has just set the inputs on a falling edge.
  // Queue this cycle's expectation, sample, then move to the next falling edge.
  task automatic applyStimulus(input string tag, input logic [3:0] f,
                               input logic s, input logic b, input logic o);
    expT e;
    e.tag = tag; e.fwd = f; e.stall = s; e.busy = b; e.ovr = o;
    sbQ.push_back(e);
    #2;
    sampleOutputs();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1; idRs = '0; exRs = '0; exRd = '0; exWb = 1'b0; exLoad = 1'b0;
    memRd = '0; memWb = 1'b0; wbRd = '0; wbWb = 1'b0; wb2Rd = '0; wb2Wb = 1'b0;
    mcStart = 1'b0; mcRd = '0;
    @(negedge clk);

    // Reset held: outputs quiet, forwarding still live
    memRd = 5'd5; memWb = 1'b1; exRs = {5'd0, 5'd5};
    applyStimulus("rstHold", 4'b0010, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Forwarding priority and x0
    wbRd = 5'd5; wbWb = 1'b1; exRs = {5'd5, 5'd5};
    applyStimulus("exmemWins", 4'b1010, 1'b0, 1'b0, 1'b0);
    memWb = 1'b0;
    applyStimulus("memwbOnly", 4'b0101, 1'b0, 1'b0, 1'b0);
    exRs = {5'd0, 5'd6}; memRd = 5'd0; memWb = 1'b1; wbRd = 5'd6; wbWb = 1'b1;
    applyStimulus("x0NoFwd", 4'b0001, 1'b0, 1'b0, 1'b0);
    memRd = 5'd12; memWb = 1'b1; wbRd = 5'd12; wbWb = 1'b0; exRs = {5'd12, 5'd28};
    applyStimulus("fullWidth", 4'b1000, 1'b0, 1'b0, 1'b0);
    wb2Rd = 5'd3; wb2Wb = 1'b1; memRd = 5'd4; wbRd = 5'd5; wbWb = 1'b1;
    exRs = {5'd4, 5'd3};
    applyStimulus("wb2Sel", {2'b10, WB2EXP}, 1'b0, 1'b0, 1'b0);
    memWb = 1'b0; wbWb = 1'b0; wb2Wb = 1'b0; exRs = '0;

    // Load-use: exactly LOAD_LAT stall cycles
    exLoad = 1'b1; exWb = 1'b1; exRd = 5'd7; idRs = {5'd7, 5'd0};
    applyStimulus("lu0", 4'b0000, 1'b1, 1'b0, 1'b0);
    exLoad = 1'b0; exWb = 1'b0;
    applyStimulus("lu1", 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("lu2", 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("lu3", 4'b0000, 1'b0, 1'b0, 1'b0);
    exLoad = 1'b1; exWb = 1'b1; exRd = 5'd0; idRs = '0;
    applyStimulus("luX0", 4'b0000, 1'b0, 1'b0, 1'b0);
    exRd = 5'd7; exWb = 1'b0; idRs = {5'd7, 5'd0};
    applyStimulus("luNoWb", 4'b0000, 1'b0, 1'b0, 1'b0);
    exLoad = 1'b0; idRs = '0;

    // Multicycle op: MC_LAT busy cycles, overrun is sticky
    mcStart = 1'b1; mcRd = 5'd9; idRs = {5'd0, 5'd9};
    applyStimulus("mc0", 4'b0000, 1'b0, 1'b0, 1'b0);
    mcStart = 1'b0;
    applyStimulus("mc1", 4'b0000, 1'b1, 1'b1, 1'b0);
    mcStart = 1'b1; mcRd = 5'd11;
    applyStimulus("mc2", 4'b0000, 1'b1, 1'b1, 1'b0);
    mcStart = 1'b0;
    applyStimulus("mc3", 4'b0000, 1'b1, 1'b1, 1'b1);
    applyStimulus("mc4", 4'b0000, 1'b1, 1'b1, 1'b1);
    applyStimulus("mc5", 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus("mc6", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Reset during LU_HOLD and a busy op aborts both
    exLoad = 1'b1; exWb = 1'b1; exRd = 5'd7; idRs = {5'd7, 5'd9};
    mcStart = 1'b1; mcRd = 5'd9;
    applyStimulus("rs0", 4'b0000, 1'b1, 1'b0, 1'b1);
    exLoad = 1'b0; exWb = 1'b0; mcStart = 1'b0;
    applyStimulus("rs1", 4'b0000, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus("rs2", 4'b0000, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    applyStimulus("rs3", 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus("rs4", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the RV32 pipeline.
- Generates per-operand bypass selects for NRS source operands, with priority across EX/MEM, MEM/WB and an optional WB-write stage.
- Detects load-use hazards and holds the front end for a programmable load latency.
- Tracks one in-flight multicycle op (mul/div) with a scoreboard.
- Sits beside the ID/EX control path; drives the EX operand muxes, PC/IF-ID enables and the ID/EX bubble.

Parameters:
- NRS, 2, number of source operands checked per instruction.
- AW, 5, register address width.
- LOAD_LAT, 1, load-use stall cycles (≥1); values >1 model a multi-cycle data memory.
- MC_LAT, 4, multicycle-unit latency in cycles (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  NRS*AW  source regs of the ID instruction; operand i at [i*AW +: AW].
- ex_rs  in  NRS*AW  source regs of the EX instruction.
- ex_rd  in  AW  dest of the EX instruction.
- ex_wb  in  1  EX instruction writes a register.
- ex_load  in  1  EX instruction is a load.
- mem_rd  in  AW  EX/MEM dest.
- mem_wb  in  1  EX/MEM regwrite.
- wb_rd  in  AW  MEM/WB dest.
- wb_wb  in  1  MEM/WB regwrite.
- wb2_rd  in  AW  post-WB dest (used only with WB_BYPASS_EN).
- wb2_wb  in  1  post-WB regwrite (used only with WB_BYPASS_EN).
- mc_start  in  1  EX issues a multicycle op this cycle.
- mc_rd  in  AW  dest of that op.
- fwd_sel  out  NRS*2  per-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 post-WB.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero ID/EX control.
- mc_busy  out  1  multicycle op in flight.
- mc_overrun  out  1  sticky; set when mc_start arrives while busy.

Behaviour:
Reset:
- rst=1 for one edge puts the FSM in IDLE and clears lu_cnt, mc_cnt, mc_busy and mc_overrun.
- stall and bubble are 0 while rst=1.
- fwd_sel is combinational and unaffected by reset.

Forwarding (combinational, zero latency), per operand i:
- Select 10 if mem_wb and mem_rd≠0 and mem_rd==ex_rs[i].
- Otherwise select 01 if wb_wb and wb_rd≠0 and wb_rd==ex_rs[i].
- Otherwise select 11 if the feature is enabled and the same test passes on wb2.
- Otherwise select 00.
- Register x0 never forwards.
- Comparison is full AW-bit equality.
- All fwd_sel bits are driven on every path; no latches.

Load-use hazard (FSM states IDLE, LU_HOLD):
- lu_hit = ex_load & ex_wb & ex_rd≠0 & (ex_rd matches any id_rs[i]).
- IDLE: lu_hit asserts stall=bubble=1 combinationally the same cycle.
  - If LOAD_LAT>1, go to LU_HOLD with lu_cnt=LOAD_LAT-2.
  - If LOAD_LAT=1, stay in IDLE.
- LU_HOLD: stall=bubble=1. If lu_cnt==0 go to IDLE, else decrement.
- Total stall length is exactly LOAD_LAT cycles.

Multicycle scoreboard:
- mc_start while !mc_busy: next edge sets mc_busy=1, latches mc_rd, mc_cnt=MC_LAT-1.
- Each busy cycle decrements mc_cnt; mc_busy clears on the edge where mc_cnt reaches 0.
- mc_busy is therefore high for exactly MC_LAT cycles.
- While busy, an id_rs[i] equal to the latched rd (≠0) asserts stall=bubble=1.
- A latched rd of 0 never stalls.
- mc_start while busy is ignored and sets mc_overrun, which holds until rst.
- On the clearing edge itself no stall is generated; the result is forwarded via MEM/WB.

Combination and reset:
- stall = bubble = lu stall OR mc stall; simultaneous causes do not extend either counter.
- rst mid-stall or mid-op aborts immediately: IDLE, mc_busy=0, no residual stall.

Optional Feature:
WB_BYPASS_EN
- Defined: the post-WB comparison is active and select 11 is generated (for register files without write-through).
- Undefined: wb2_rd and wb2_wb are ignored, select 11 is never produced, and the ports remain present and unused.

Decomposition:
- Package fwd_pkg holds:
  - select constants FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01, FWD_WB2=2'b11;
  - the FSM state enum {IDLE, LU_HOLD};
  - the helper function rd_hit(rd, wb, rs), returning wb & rd≠0 & rd==rs.
- One sub-module, fwd_sel_one, is instantiated NRS times via generate. It takes one rs plus the stage rd/wb signals and outputs a 2-bit select.

Test Plan:
- mem_rd=5, mem_wb=1, wb_rd=5, wb_wb=1, ex_rs0=5 -> fwd_sel[1:0]=10 (EX/MEM wins); set mem_wb=0 -> 01.
- ex_rs1=0, mem_rd=0, mem_wb=1 -> fwd_sel[3:2]=00; no forwarding for x0.
- LOAD_LAT=3, ex_load=1, ex_wb=1, ex_rd=7, id_rs1=7 -> stall=bubble=1 for exactly 3 cycles, then 0.
- MC_LAT=4, mc_start with mc_rd=9, id_rs0=9 held -> mc_busy high 4 cycles, stall high for those same 4 cycles; second mc_start on cycle 2 -> mc_overrun=1 and sticky.
- rst asserted during LU_HOLD and mc_busy -> next cycle stall=0, mc_busy=0, mc_overrun=0.
- With WB_BYPASS_EN: wb2_rd=3, wb2_wb=1, ex_rs0=3, other stages miss -> 11; without the macro -> 00.
